// File: rtl/opcode_decoder_seq.sv
// opcode_decoder_seq: registered one-hot opcode decoder with valid/ready on
// both sides, illegal-opcode flagging and a busy window for multicycle ops.
// Optional statistics counters are compiled in with `define DECODE_STATS_EN;
// without it op_count and illegal_count are constant zero.
module opcode_decoder_seq #(
  parameter int OPCODE_W  = 5,
  parameter int NUM_OUT   = 8,
  parameter int MC_FIRST  = 6,
  parameter int MC_LAST   = 7,
  parameter int MC_CYCLES = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_OUT-1:0]  out_sel,
  output logic                illegal,
  output logic                busy,
  output logic [15:0]         op_count,
  output logic [15:0]         illegal_count
);

  localparam int CNT_W = $clog2(MC_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    MULTI,
    ISSUE
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_OUT-1:0] sel_q, sel_d;
  logic               illegal_q, illegal_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [31:0]        opcode_ext;
  logic [NUM_OUT-1:0] sel_dec;
  logic               op_illegal;
  logic               op_multi;
  logic               accept;

  // Opcode comparisons are done on a zero-extended copy so they stay unsigned.
  assign opcode_ext = 32'(opcode);
  assign op_illegal = (opcode_ext >= 32'(NUM_OUT));
  assign op_multi   = !op_illegal &&
                      (opcode_ext >= 32'(MC_FIRST)) &&
                      (opcode_ext <= 32'(MC_LAST));

  // One comparator per select bit; an illegal opcode matches none of them.
  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_dec
    assign sel_dec[gi] = (opcode_ext == 32'(gi));
  end

  assign in_ready  = (state_q == IDLE) && !reset;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ISSUE);
  assign busy      = (state_q == MULTI);
  assign out_sel   = sel_q;
  assign illegal   = illegal_q;

  // Next-state logic: latch the decode on accept, count down the multicycle
  // window, then hold the result until the consumer takes it.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        sel_d     = '0;
        illegal_d = 1'b0;
        if (accept) begin
          if (op_illegal) begin
            state_d   = ISSUE;
            illegal_d = 1'b1;
          end else if (op_multi) begin
            state_d = MULTI;
            sel_d   = sel_dec;
            cnt_d   = CNT_W'(MC_CYCLES);
          end else begin
            state_d = ISSUE;
            sel_d   = sel_dec;
          end
        end
      end
      MULTI: begin
        // Counter was loaded with MC_CYCLES, so leaving at 1 gives exactly
        // MC_CYCLES cycles of busy.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ISSUE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ISSUE: begin
        if (out_ready) begin
          state_d   = IDLE;
          sel_d     = '0;
          illegal_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        sel_d     = '0;
        illegal_d = 1'b0;
        cnt_d     = '0;
      end
    endcase
  end

  // State and result registers; reset drops any op in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef DECODE_STATS_EN
  logic [15:0] op_cnt_q, op_cnt_d;
  logic [15:0] ill_cnt_q, ill_cnt_d;
  logic        out_hs;

  assign out_hs = out_valid && out_ready;

  // Saturating counts of legal and illegal results handed downstream.
  always_comb begin
    op_cnt_d  = op_cnt_q;
    ill_cnt_d = ill_cnt_q;
    if (out_hs && !illegal_q && (op_cnt_q != 16'hFFFF)) begin
      op_cnt_d = op_cnt_q + 16'd1;
    end
    if (out_hs && illegal_q && (ill_cnt_q != 16'hFFFF)) begin
      ill_cnt_d = ill_cnt_q + 16'd1;
    end
  end

  // Statistics registers, cleared with the rest of the block.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_cnt_q  <= 16'h0000;
      ill_cnt_q <= 16'h0000;
    end else begin
      op_cnt_q  <= op_cnt_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  assign op_count      = op_cnt_q;
  assign illegal_count = ill_cnt_q;
`else
  assign op_count      = 16'h0000;
  assign illegal_count = 16'h0000;
`endif

endmodule

// File: tb/tb_opcode_decoder_seq.sv
// tb_opcode_decoder_seq: scenario tasks for opcode_decoder_seq with a
// queue of expected results filled on accept and drained on output.
module tb_opcode_decoder_seq;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  opcode;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_sel;
  logic        illegal;
  logic        busy;
  logic [15:0] op_count;
  logic [15:0] illegal_count;

`ifdef DECODE_STATS_EN
  localparam int STATS_ON = 1;
`else
  localparam int STATS_ON = 0;
`endif

  typedef struct packed {
    logic [7:0] sel;
    logic       ill;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  opcode_decoder_seq dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opcode       (opcode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sel      (out_sel),
    .illegal      (illegal),
    .busy         (busy),
    .op_count     (op_count),
    .illegal_count(illegal_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic exp_t model(input int op);
    exp_t e;
    logic [7:0] one;
    one   = 8'd1;
    e.ill = (op >= 8);
    e.sel = (op >= 8) ? 8'h00 : (one << op);
    return e;
  endfunction

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; opcode = '0;
    tick; tick;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_sel !== 8'h00) begin errors++; $display("FAIL rst_out_sel: got %h expected 00", out_sel); end
    checks++; if (illegal !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_flags: got illegal=%b busy=%b expected 0 0", illegal, busy); end
    checks++; if (op_count !== 16'h0 || illegal_count !== 16'h0) begin errors++; $display("FAIL rst_counts: got %h %h expected 0 0", op_count, illegal_count); end
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", in_ready); end
    $display("txn reset: done");
  endtask

  // Accept a non-multicycle opcode with out_ready high; result on the next cycle.
  task automatic test_single(input int op);
    exp_t e;
    out_ready = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready_pre: got %b expected 1", in_ready); end
    in_valid = 1'b1; opcode = 5'(op);
    sb_q.push_back(model(op));
    tick;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_latency: out_valid got %b expected 1", out_valid); end
    checks++; if (sb_q.size() == 0) begin errors++; $display("FAIL single_sb: queue size got 0 expected 1"); end
    else begin
      e = sb_q.pop_front();
      checks++; if (out_sel !== e.sel) begin errors++; $display("FAIL single_sel op=%0d: got %h expected %h", op, out_sel, e.sel); end
      checks++; if (illegal !== e.ill) begin errors++; $display("FAIL single_illegal op=%0d: got %b expected %b", op, illegal, e.ill); end
    end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL single_busy_ready: got busy=%b in_ready=%b expected 0 0", busy, in_ready); end
    tick;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sel !== 8'h00) begin errors++; $display("FAIL single_return_idle: got in_ready=%b out_valid=%b sel=%h expected 1 0 00", in_ready, out_valid, out_sel); end
    $display("txn single op=%0d sel=%h illegal=%b", op, e.sel, e.ill);
  endtask

  // Multicycle opcode: 32 busy cycles, in_valid pulses ignored, then issue.
  task automatic test_multi(input int op);
    exp_t e;
    int   bad;
    out_ready = 1'b1;
    in_valid = 1'b1; opcode = 5'(op);
    sb_q.push_back(model(op));
    tick;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0 || out_sel !== model(op).sel) bad++;
      in_valid = (i % 3 == 0); opcode = 5'd2;
      tick;
    end
    in_valid = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL multi_window op=%0d: got %0d bad cycles expected 0", op, bad); end
    checks++; if (out_valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL multi_latency op=%0d: got out_valid=%b busy=%b expected 1 0", op, out_valid, busy); end
    checks++; if (sb_q.size() == 0) begin errors++; $display("FAIL multi_sb: queue size got 0 expected 1"); end
    else begin
      e = sb_q.pop_front();
      checks++; if (out_sel !== e.sel || illegal !== e.ill) begin errors++; $display("FAIL multi_result op=%0d: got sel=%h ill=%b expected %h %b", op, out_sel, illegal, e.sel, e.ill); end
    end
    tick;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL multi_return_idle: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid); end
    $display("txn multi op=%0d sel=%h", op, e.sel);
  endtask

  // Result held under backpressure; stray in_valid while not ready is ignored.
  task automatic test_backpressure;
    exp_t e;
    int   bad;
    out_ready = 1'b0;
    in_valid = 1'b1; opcode = 5'd1;
    sb_q.push_back(model(1));
    tick;
    e = sb_q.pop_front();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid !== 1'b1 || out_sel !== e.sel || illegal !== e.ill || in_ready !== 1'b0) bad++;
      in_valid = 1'b1; opcode = 5'd3;
      out_ready = (i == 3);
      tick;
    end
    in_valid = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold: got %0d bad cycles expected 0", bad); end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sel !== 8'h00) begin errors++; $display("FAIL bp_release: got out_valid=%b in_ready=%b sel=%h expected 0 1 00", out_valid, in_ready, out_sel); end
    $display("txn backpressure op=1 sel=%h held 4 cycles", e.sel);
  endtask

  // Reset during the multicycle window drops the op entirely.
  task automatic test_reset_mid_multi;
    int seen;
    out_ready = 1'b1;
    in_valid = 1'b1; opcode = 5'd7;
    sb_q.push_back(model(7));
    tick;
    in_valid = 1'b0;
    for (int i = 1; i < 10; i++) tick;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmm_busy10: got %b expected 1", busy); end
    reset = 1'b1;
    tick;
    sb_q.delete();
    checks++; if (out_valid !== 1'b0 || out_sel !== 8'h00 || illegal !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL rmm_outputs: got v=%b sel=%h ill=%b busy=%b rdy=%b expected all 0", out_valid, out_sel, illegal, busy, in_ready);
    end
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmm_ready: got %b expected 1", in_ready); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1) seen++;
      tick;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rmm_no_output: got %0d valid cycles expected 0", seen); end
    $display("txn reset_mid_multi op=7 dropped");
  endtask

  // Stream with in_valid always offered and out_ready high: one op per 2 cycles.
  task automatic test_back_to_back;
    int   ops[5];
    int   idx, cyc, hs;
    logic exp_rdy;
    exp_t e;
    ops = '{0, 2, 9, 4, 12};
    idx = 0; cyc = 0; hs = 0; exp_rdy = 1'b1;
    out_ready = 1'b1;
    while (hs < 5 && cyc < 40) begin
      checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL b2b_ready cyc=%0d: got %b expected %b", cyc, in_ready, exp_rdy); end
      if (out_valid === 1'b1) begin
        checks++; if (sb_q.size() == 0) begin errors++; $display("FAIL b2b_sb: unexpected output sel=%h", out_sel); end
        else begin
          e = sb_q.pop_front();
          checks++; if (out_sel !== e.sel || illegal !== e.ill) begin errors++; $display("FAIL b2b_result: got sel=%h ill=%b expected %h %b", out_sel, illegal, e.sel, e.ill); end
          $display("txn b2b out sel=%h illegal=%b", out_sel, illegal);
        end
        hs++;
      end
      if (exp_rdy && idx < 5) begin
        in_valid = 1'b1; opcode = 5'(ops[idx]);
        sb_q.push_back(model(ops[idx]));
        idx++;
        exp_rdy = 1'b0;
      end else begin
        in_valid = 1'b0;
        exp_rdy = 1'b1;
      end
      tick;
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (hs != 5 || cyc != 10) begin errors++; $display("FAIL b2b_throughput: got %0d ops in %0d cycles expected 5 in 10", hs, cyc); end
  endtask

  // Counters after 3 legal and 2 illegal handshakes from a fresh reset.
  task automatic test_stats;
    reset = 1'b1; in_valid = 1'b0;
    tick; tick;
    reset = 1'b0;
    #1;
    test_back_to_back;
    checks++; if (op_count !== 16'(STATS_ON * 3)) begin errors++; $display("FAIL stats_op_count: got %0d expected %0d", op_count, STATS_ON * 3); end
    checks++; if (illegal_count !== 16'(STATS_ON * 2)) begin errors++; $display("FAIL stats_illegal_count: got %0d expected %0d", illegal_count, STATS_ON * 2); end
    $display("txn stats op_count=%0d illegal_count=%0d", op_count, illegal_count);
  endtask

  initial begin
    test_reset;
    test_single(3);
    test_multi(6);
    test_single(9);
    test_single(0);
    test_backpressure;
    test_multi(7);
    test_reset_mid_multi;
    test_stats;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
